// File: rtl/disp_pkg.sv
// Shared definitions for the shared seven-segment display controller:
// owner state encoding, blank codes, digit packing offsets and a width helper.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } disp_state_t;

    localparam logic [3:0]  BLANK_DIGIT = 4'hF;
    localparam logic [15:0] BLANK_WORD  = {4{BLANK_DIGIT}};

    localparam int DIGIT_W  = 4;
    localparam int DIG1_LSB = 0;
    localparam int DIG2_LSB = 4;
    localparam int DIG3_LSB = 8;
    localparam int DIG4_LSB = 12;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1)
            return 1;
        return $clog2(max_val + 1);
    endfunction

    function automatic logic [1:0] gnt_of(input disp_state_t s);
        case (s)
            ST_OWN0: return 2'b01;
            ST_OWN1: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
module disp_tick_gen
    import disp_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int               CNT_W = cnt_width(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/disp_share_ctrl.sv
// Two-requester ownership arbiter for the 4-digit display with a minimum hold
// before requester 1 may preempt requester 0. DISP_FLASH_EN flashes requester 1.
module disp_share_ctrl
    import disp_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int MIN_HOLD    = 200,
    parameter int FLASH_TICKS = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] src0_dig,
    input  logic [15:0] src1_dig,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic [3:0]  dig4,
    output logic [3:0]  dig3,
    output logic [3:0]  dig2,
    output logic [3:0]  dig1
);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("disp_share_ctrl: TICK_DIV must be at least 2");
    end
    if (FLASH_TICKS < 1) begin : g_bad_flash_ticks
        $error("disp_share_ctrl: FLASH_TICKS must be at least 1");
    end

    localparam int                HOLD_W   = cnt_width(MIN_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

    disp_state_t       state;
    disp_state_t       state_nxt;
    logic              state_change;
    logic              tick;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic              show_src1;
    logic [15:0]       dig_word;
    logic [15:0]       dig_word_nxt;

    disp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Requester 1 wins ties; requester 0 is only displaced once its hold is done.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req[1])
                    state_nxt = ST_OWN1;
                else if (req[0])
                    state_nxt = ST_OWN0;
            end
            ST_OWN0: begin
                if (!req[0])
                    state_nxt = req[1] ? ST_OWN1 : ST_IDLE;
                else if (req[1] && hold_done)
                    state_nxt = ST_OWN1;
            end
            ST_OWN1: begin
                if (!req[1])
                    state_nxt = req[0] ? ST_OWN0 : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt  = gnt_of(state);
        busy = (state != ST_IDLE);
    end

    assign state_change = (state_nxt != state);
    assign hold_done    = (hold_cnt == HOLD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (state_change)
            hold_cnt <= '0;
        else if (state == ST_OWN0 && tick && !hold_done)
            hold_cnt <= hold_cnt + HOLD_W'(1);
    end

`ifdef DISP_FLASH_EN
    localparam int                 FLASH_W    = cnt_width(FLASH_TICKS - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_TICKS - 1);

    logic [FLASH_W-1:0] flash_cnt;
    logic [FLASH_W-1:0] flash_cnt_nxt;
    logic               flash_blank;
    logic               flash_blank_nxt;

    // Phase is computed one edge ahead so the digit register and phase move together.
    always_comb begin
        flash_cnt_nxt   = flash_cnt;
        flash_blank_nxt = flash_blank;
        if (state_change) begin
            flash_cnt_nxt   = '0;
            flash_blank_nxt = 1'b0;
        end else if (state == ST_OWN1 && tick) begin
            if (flash_cnt == FLASH_LAST) begin
                flash_cnt_nxt   = '0;
                flash_blank_nxt = !flash_blank;
            end else begin
                flash_cnt_nxt = flash_cnt + FLASH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt   <= '0;
            flash_blank <= 1'b0;
        end else begin
            flash_cnt   <= flash_cnt_nxt;
            flash_blank <= flash_blank_nxt;
        end
    end

    assign show_src1 = !flash_blank_nxt;
`else
    assign show_src1 = 1'b1;
`endif

    always_comb begin
        dig_word_nxt = BLANK_WORD;
        case (state_nxt)
            ST_OWN0: dig_word_nxt = src0_dig;
            ST_OWN1: dig_word_nxt = show_src1 ? src1_dig : BLANK_WORD;
            default: dig_word_nxt = BLANK_WORD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dig_word <= BLANK_WORD;
        else
            dig_word <= dig_word_nxt;
    end

    assign dig4 = dig_word[DIG4_LSB +: DIGIT_W];
    assign dig3 = dig_word[DIG3_LSB +: DIGIT_W];
    assign dig2 = dig_word[DIG2_LSB +: DIGIT_W];
    assign dig1 = dig_word[DIG1_LSB +: DIGIT_W];

endmodule

// File: tb/tb_disp_share_ctrl.sv
// Self-checking bench for disp_share_ctrl: an owner-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_disp_share_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int MIN_HOLD    = 3;
    localparam int FLASH_TICKS = 2;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [1:0]  req      = 2'b00;
    logic [15:0] src0_dig = 16'h1234;
    logic [15:0] src1_dig = 16'h9999;
    logic [1:0]  gnt;
    logic        busy;
    logic [3:0]  dig4, dig3, dig2, dig1;
    logic [15:0] dut_word;

    int total = 0;
    int bad   = 0;

    int          k;
    int          changes;
    int          last_change;
    logic [15:0] last_word;

    disp_share_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .MIN_HOLD    (MIN_HOLD),
        .FLASH_TICKS (FLASH_TICKS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .src0_dig (src0_dig),
        .src1_dig (src1_dig),
        .gnt      (gnt),
        .busy     (busy),
        .dig4     (dig4),
        .dig3     (dig3),
        .dig2     (dig2),
        .dig1     (dig1)
    );

    assign dut_word = {dig4, dig3, dig2, dig1};

    always #5 clk = ~clk;

    // Reference model: who owns the display (-1 nobody), clocks elapsed mod
    // TICK_DIV, ticks held by requester 0 and ticks spent by requester 1.
    int          m_owner = -1;
    int          m_presc = 0;
    int          m_held  = 0;
    int          m_flash = 0;
    logic [15:0] m_word  = 16'hFFFF;

    int          n_owner;
    int          n_held;
    int          n_flash;
    logic [15:0] n_word;
    logic        m_tick;

    always_comb begin
        m_tick  = (m_presc == TICK_DIV - 1);
        n_owner = m_owner;
        if (m_owner == -1)
            n_owner = req[1] ? 1 : (req[0] ? 0 : -1);
        else if (m_owner == 0) begin
            if (!req[0])
                n_owner = req[1] ? 1 : -1;
            else if (req[1] && m_held >= MIN_HOLD)
                n_owner = 1;
        end else if (!req[1])
            n_owner = req[0] ? 0 : -1;

        n_held  = m_held;
        n_flash = m_flash;
        if (n_owner != m_owner) begin
            n_held  = 0;
            n_flash = 0;
        end else if (m_tick && m_owner == 0)
            n_held = (m_held < MIN_HOLD) ? m_held + 1 : MIN_HOLD;
        else if (m_tick && m_owner == 1)
            n_flash = m_flash + 1;

        n_word = 16'hFFFF;
        if (n_owner == 0)
            n_word = src0_dig;
        else if (n_owner == 1) begin
`ifdef DISP_FLASH_EN
            n_word = (((n_flash / FLASH_TICKS) % 2) == 0) ? src1_dig : 16'hFFFF;
`else
            n_word = src1_dig;
`endif
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_presc <= 0;
            m_held  <= 0;
            m_flash <= 0;
            m_word  <= 16'hFFFF;
        end else begin
            m_owner <= n_owner;
            m_presc <= (m_presc + 1) % TICK_DIV;
            m_held  <= n_held;
            m_flash <= n_flash;
            m_word  <= n_word;
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    initial begin
        logic [1:0] exp_gnt;
        forever begin
            @(negedge clk);
            exp_gnt = (m_owner == 0) ? 2'b01 : ((m_owner == 1) ? 2'b10 : 2'b00);
            total++;
            if (gnt !== exp_gnt || busy !== (m_owner != -1) || dut_word !== m_word) begin
                bad++;
                $display("[TB] FAIL cycle_cmp t=%0t got gnt=%b busy=%b dig=%h required gnt=%b busy=%b dig=%h",
                         $time, gnt, busy, dut_word, exp_gnt, (m_owner != -1), m_word);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] r, input int cycles);
        req = r;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] exp_gnt, input logic exp_busy,
                               input logic [15:0] exp_word, input bit check_word);
        total++;
        if (gnt !== exp_gnt || busy !== exp_busy || (check_word && dut_word !== exp_word)) begin
            bad++;
            $display("[TB] FAIL %s got gnt=%b busy=%b dig=%h required gnt=%b busy=%b dig=%h",
                     name, gnt, busy, dut_word, exp_gnt, exp_busy, exp_word);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", 2'b00, 1'b0, 16'hFFFF, 1);
        rst_n = 1'b1;
        applyStimulus(2'b00, 2);
        checkOutput("idle_after_reset", 2'b00, 1'b0, 16'hFFFF, 1);

        applyStimulus(2'b01, 1);
        checkOutput("grant0", 2'b01, 1'b1, 16'h1234, 1);
        src0_dig = 16'h5678;
        applyStimulus(2'b01, 1);
        checkOutput("live0", 2'b01, 1'b1, 16'h5678, 1);
        applyStimulus(2'b00, 1);
        checkOutput("release0", 2'b00, 1'b0, 16'hFFFF, 1);

        // Preempt must wait for three full ticks after the grant edge.
        applyStimulus(2'b01, 1);
        checkOutput("own0", 2'b01, 1'b1, 16'h5678, 1);
        applyStimulus(2'b01, 1);
        req = 2'b11;
        k   = 0;
        while (gnt != 2'b10 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (k < 9 || k > 12) begin
            bad++;
            $display("[TB] FAIL preempt_latency got %0d edges required 9..12", k);
        end
        checkOutput("preempt", 2'b10, 1'b1, 16'h9999, 1);

        applyStimulus(2'b11, 100);
        checkOutput("own1_no_preempt", 2'b10, 1'b1, 16'h0000, 0);
        applyStimulus(2'b01, 1);
        checkOutput("return0", 2'b01, 1'b1, 16'h5678, 1);

        applyStimulus(2'b00, 1);
        checkOutput("idle_again", 2'b00, 1'b0, 16'hFFFF, 1);
        applyStimulus(2'b11, 1);
        checkOutput("both_rise", 2'b10, 1'b1, 16'h9999, 1);
        applyStimulus(2'b00, 1);
        applyStimulus(2'b01, 1);
        checkOutput("own0_b", 2'b01, 1'b1, 16'h5678, 1);
        applyStimulus(2'b10, 1);
        checkOutput("switch_direct", 2'b10, 1'b1, 16'h9999, 1);

        // A one-cycle drop loses ownership and the hold restarts from zero.
        applyStimulus(2'b01, 1);
        checkOutput("own0_c", 2'b01, 1'b1, 16'h5678, 1);
        applyStimulus(2'b01, 5);
        applyStimulus(2'b00, 1);
        checkOutput("drop", 2'b00, 1'b0, 16'hFFFF, 1);
        applyStimulus(2'b01, 1);
        checkOutput("regrant", 2'b01, 1'b1, 16'h5678, 1);
        applyStimulus(2'b01, 1);
        applyStimulus(2'b11, 8);
        checkOutput("hold_restart", 2'b01, 1'b1, 16'h5678, 1);

        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 2'b00, 1'b0, 16'hFFFF, 1);
        applyStimulus(2'b00, 2);
        rst_n = 1'b1;
        applyStimulus(2'b00, 2);
        checkOutput("post_reset_idle", 2'b00, 1'b0, 16'hFFFF, 1);
        applyStimulus(2'b01, 1);
        checkOutput("first_grant", 2'b01, 1'b1, 16'h5678, 1);

        // Ten ticks in OWN1: the digit word either flashes with an 8-clock period or stays put.
        applyStimulus(2'b10, 1);
        checkOutput("own1_entry", 2'b10, 1'b1, 16'h9999, 1);
        last_word   = dut_word;
        last_change = -1;
        changes     = 0;
        for (int c = 1; c <= 40; c++) begin
            applyStimulus(2'b10, 1);
            checkOutput("own1_gnt_steady", 2'b10, 1'b1, 16'h0000, 0);
            if (dut_word != last_word) begin
                if (last_change >= 0) begin
                    total++;
                    if (c - last_change != 8) begin
                        bad++;
                        $display("[TB] FAIL flash_period got %0d clks required 8", c - last_change);
                    end
                end
                last_change = c;
                last_word   = dut_word;
                changes++;
            end
        end
        total++;
`ifdef DISP_FLASH_EN
        if (changes < 4) begin
            bad++;
            $display("[TB] FAIL flash_toggles got %0d required at least 4", changes);
        end
`else
        if (changes != 0) begin
            bad++;
            $display("[TB] FAIL steady_own1 got %0d digit changes required 0", changes);
        end
`endif

        applyStimulus(2'b00, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
